// File: rtl/eql_gen.sv
// eql_gen: request-match / count-compare handshake generator for a request handler.
// Outputs are registered decodes; optional protocol checker enabled by EQL_GEN_CHECK_EN.
module eql_gen #(
    parameter int HOLD_CYC  = 2,
    parameter int TIMEOUT   = 16,
    parameter int CNT_LIMIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ENIN_REQ,
    input  logic       INTR_REQ,
    input  logic [2:1] CC_MUX,
    input  logic [2:1] USCITE,
    input  logic       ENABLE_COUNT,
    input  logic       ACKOUT,
    output logic       EQL,
    output logic       CONT_EQL,
    output logic       SRC,
    output logic       TO_ERR,
    output logic       PROT_ERR
);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_ACK, S_DONE} state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYC);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] CNT_LIM   = 8'(CNT_LIMIT);

    state_t     state, state_nxt;
    logic       enin_pend, intr_pend, src_q, to_err;
    logic [3:0] hold_cnt;
    logic [7:0] to_cnt, cnt;
    logic       take_enin, take_intr, ack_seen, to_hit;

    always_comb begin
        state_nxt = state;
        take_enin = 1'b0;
        take_intr = 1'b0;
        ack_seen  = 1'b0;
        to_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (CC_MUX == 2'b01 && enin_pend) begin
                    state_nxt = S_ASSERT;
                    take_enin = 1'b1;
                end else if (CC_MUX == 2'b10 && intr_pend) begin
                    state_nxt = S_ASSERT;
                    take_intr = 1'b1;
                end
            end
            S_ASSERT: begin
                // Ack wins over a timeout landing in the same cycle.
                if (CC_MUX == 2'b11) begin
                    state_nxt = S_ACK;
                    ack_seen  = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_IDLE;
                    to_hit    = 1'b1;
                end
            end
            S_ACK: begin
                if (hold_cnt == 4'd0) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (USCITE == 2'b01) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enin_pend <= 1'b0;
            intr_pend <= 1'b0;
            src_q     <= 1'b0;
            to_err    <= 1'b0;
            hold_cnt  <= 4'd0;
            to_cnt    <= 8'd0;
            cnt       <= 8'd0;
        end else begin
            if (take_enin)      src_q <= 1'b0;
            else if (take_intr) src_q <= 1'b1;

            // A new request pulse beats a coincident clear.
            enin_pend <= ENIN_REQ | (enin_pend & ~(ack_seen & ~src_q));
            intr_pend <= INTR_REQ | (intr_pend & ~(ack_seen &  src_q));

            // Held at zero outside S_ASSERT so entry always starts from zero.
            if (state == S_ASSERT) to_cnt <= to_cnt + 8'd1;
            else                   to_cnt <= 8'd0;

            if (ack_seen)                                hold_cnt <= HOLD_INIT;
            else if (state == S_ACK && hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;

            if (to_hit) to_err <= 1'b1;

            if (ENABLE_COUNT) begin
                if (cnt != CNT_LIM) cnt <= cnt + 8'd1;
            end else if (cnt == CNT_LIM) begin
                cnt <= 8'd0;
            end
        end
    end

    assign EQL      = (state == S_ASSERT) || (state == S_ACK);
    assign CONT_EQL = (cnt == CNT_LIM);
    assign SRC      = src_q;
    assign TO_ERR   = to_err;

`ifdef EQL_GEN_CHECK_EN
    logic prot_err;

    always_ff @(posedge clk) begin
        if (reset)                                             prot_err <= 1'b0;
        else if (USCITE == 2'b10 || ENABLE_COUNT != ACKOUT)    prot_err <= 1'b1;
    end

    assign PROT_ERR = prot_err;
`else
    logic unused_ackout;
    assign unused_ackout = ACKOUT;
    assign PROT_ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_eql_gen.sv
// Scoreboard bench for eql_gen: directed handshake scenarios followed by random traffic,
// each cycle's expected outputs come from a phase-level model of the handshake rules.
module tb_eql_gen;

    localparam int HOLD = 2;
    localparam int TMO  = 4;
    localparam int LIM  = 3;

    logic       clk = 1'b0;
    logic       reset, enin_req, intr_req, enable_count, ackout;
    logic [2:1] cc_mux, uscite;
    logic       eql, cont_eql, src, to_err, prot_err;

    eql_gen #(.HOLD_CYC(HOLD), .TIMEOUT(TMO), .CNT_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .ENIN_REQ(enin_req), .INTR_REQ(intr_req),
        .CC_MUX(cc_mux), .USCITE(uscite), .ENABLE_COUNT(enable_count), .ACKOUT(ackout),
        .EQL(eql), .CONT_EQL(cont_eql), .SRC(src), .TO_ERR(to_err), .PROT_ERR(prot_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic eql, cont, src, to, prot;
        int   id;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc_id = 0;

    // Model: phase 0 idle, 1 waiting for ack, 2 holding after ack, 3 done.
    int m_phase, m_wait, m_held, m_cnt;
    bit m_src, m_ep, m_ip, m_to, m_prot;

    function automatic void model_reset();
        m_phase = 0; m_wait = 0; m_held = 0; m_cnt = 0;
        m_src = 0; m_ep = 0; m_ip = 0; m_to = 0; m_prot = 0;
    endfunction

    function automatic void model_step(bit r, bit ei, bit ii, int cc, int us, bit en, bit ak);
        bit clr_e, clr_i;
        if (r) begin
            model_reset();
            return;
        end
        clr_e = 0; clr_i = 0;
        case (m_phase)
            0: if (cc == 1 && m_ep) begin m_phase = 1; m_src = 0; m_wait = 0; end
               else if (cc == 2 && m_ip) begin m_phase = 1; m_src = 1; m_wait = 0; end
            1: if (cc == 3) begin
                   m_phase = 2; m_held = 0;
                   if (m_src) clr_i = 1; else clr_e = 1;
               end else if (m_wait + 1 == TMO) begin
                   m_phase = 0; m_to = 1;
               end else m_wait++;
            2: if (m_held == HOLD) m_phase = 3; else m_held++;
            default: if (us == 1) m_phase = 0;
        endcase
        m_ep = (m_ep && !clr_e) || ei;
        m_ip = (m_ip && !clr_i) || ii;
        if (en) m_cnt = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
        else if (m_cnt == LIM) m_cnt = 0;
`ifdef EQL_GEN_CHECK_EN
        if (us == 2 || en != ak) m_prot = 1;
`endif
    endfunction

    // Apply inputs for the next edge and queue the outputs expected after it.
    task automatic cyc(bit r, bit ei, bit ii, int cc, int us, bit en, bit ak);
        exp_t e;
        reset = r; enin_req = ei; intr_req = ii;
        cc_mux = 2'(cc); uscite = 2'(us); enable_count = en; ackout = ak;
        model_step(r, ei, ii, cc, us, en, ak);
        e.eql = (m_phase == 1 || m_phase == 2);
        e.cont = (m_cnt == LIM);
        e.src = m_src; e.to = m_to; e.prot = m_prot;
        e.id = cyc_id++;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(string name, int id, logic act, logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, id, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("EQL", e.id, eql, e.eql);
                chk("CONT_EQL", e.id, cont_eql, e.cont);
                chk("SRC", e.id, src, e.src);
                chk("TO_ERR", e.id, to_err, e.to);
                chk("PROT_ERR", e.id, prot_err, e.prot);
            end
        end
    end

    initial begin : stim
        int cc, us;
        bit en, ak;
        model_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Enin handshake with hold, then done.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        // Intr pulse with wrong selector, then right one; request and select together.
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 2, 0, 0, 0);
        cyc(0, 0, 0, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0);
        // Timeout, pending flag survives and re-asserts.
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 3, 0, 0, 0);
        // Reset in the middle of the hold.
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 2, 0, 0, 0);
        // Count saturation and clear, counting straight out of reset.
        cyc(1, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Protocol violation for one cycle.
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cc = int'($urandom_range(0, 3));
            us = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(0, 3));
            en = 1'($urandom_range(0, 1));
            ak = ($urandom_range(0, 15) == 0) ? !en : en;
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0, cc, us, en, ak);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
